// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter for a single-ported fixed-latency memory
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   i_req/i_addr -> i_rdata/i_ack                 fetch port (read-only)
//   d_re/d_we/d_addr/d_wdata -> d_rdata/d_ack     data port (load/store)
//   stall_if, stall_mem         combinational pipeline freezes while a request is unanswered
//   mem_en/mem_we/mem_addr/mem_wdata -> mem_rdata memory side; mem_rdata valid in last mem_en cycle
module mem_port_arbiter #(
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 16,
   parameter int MEM_LAT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic [DATA_W-1:0] i_rdata,
   output logic              i_ack,
   input  logic              d_re,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_ack,
   output logic              stall_if,
   output logic              stall_mem,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, ACK} state_t;

   localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              last_grant_q, last_grant_d;   // 1: most recent grant went to the data port
   logic              i_ack_q, i_ack_d;
   logic              d_ack_q, d_ack_d;
   logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
   logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
   logic              mem_en_q, mem_en_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

   logic d_pend;
   logic grant_d;

   assign d_pend = d_re | d_we;
   // Data wins when alone, or under contention when fetch won last; this
   // alternates the ports so neither starves.
   assign grant_d = d_pend && (!i_req || !last_grant_q);

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      last_grant_d = last_grant_q;
      i_ack_d      = i_ack_q;
      d_ack_d      = d_ack_q;
      i_rdata_d    = i_rdata_q;
      d_rdata_d    = d_rdata_q;
      mem_en_d     = mem_en_q;
      mem_we_d     = mem_we_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      case (state_q)
         IDLE: begin
            if (d_pend || i_req) begin
               mem_en_d     = 1'b1;
               cnt_d        = CNT_INIT;
               last_grant_d = grant_d;
               if (grant_d) begin
                  state_d    = BUSY_D;
                  mem_addr_d = d_addr;
                  // A simultaneous read+write request is treated as a write.
                  mem_we_d   = d_we;
                  if (d_we) mem_wdata_d = d_wdata;
               end else begin
                  state_d    = BUSY_I;
                  mem_addr_d = i_addr;
                  mem_we_d   = 1'b0;
               end
            end
         end
         BUSY_I, BUSY_D: begin
            if (cnt_q == 4'd0) begin
               mem_en_d = 1'b0;
               mem_we_d = 1'b0;
               state_d  = ACK;
               if (state_q == BUSY_I) begin
                  i_ack_d   = 1'b1;
                  i_rdata_d = mem_rdata;
               end else begin
                  d_ack_d = 1'b1;
                  // mem_we_q still reflects the access in flight here.
                  if (!mem_we_q) d_rdata_d = mem_rdata;
               end
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ACK: begin
            i_ack_d = 1'b0;
            d_ack_d = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         cnt_q        <= 4'd0;
         last_grant_q <= 1'b0;
         i_ack_q      <= 1'b0;
         d_ack_q      <= 1'b0;
         i_rdata_q    <= '0;
         d_rdata_q    <= '0;
         mem_en_q     <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         last_grant_q <= last_grant_d;
         i_ack_q      <= i_ack_d;
         d_ack_q      <= d_ack_d;
         i_rdata_q    <= i_rdata_d;
         d_rdata_q    <= d_rdata_d;
         mem_en_q     <= mem_en_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
      end
   end

   assign i_ack     = i_ack_q;
   assign d_ack     = d_ack_q;
   assign i_rdata   = i_rdata_q;
   assign d_rdata   = d_rdata_q;
   assign mem_en    = mem_en_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign stall_if  = i_req && !i_ack_q;
   assign stall_mem = d_pend && !d_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

   localparam int LAT = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic        i_req, i_ack, d_re, d_we, d_ack, stall_if, stall_mem, mem_en, mem_we;
   logic [15:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata, mem_addr, mem_wdata, mem_rdata;

   logic        b_i_req, b_i_ack, b_d_re, b_d_we, b_d_ack, b_stall_if, b_stall_mem, b_mem_en, b_mem_we;
   logic [15:0] b_i_addr, b_i_rdata, b_d_addr, b_d_wdata, b_d_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;

   int n_checks = 0;
   int n_fail   = 0;

   mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(LAT)) dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
      .d_re(d_re), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ack(d_ack),
      .stall_if(stall_if), .stall_mem(stall_mem),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(1)) dut_lat1 (
      .clk(clk), .rst(rst),
      .i_req(b_i_req), .i_addr(b_i_addr), .i_rdata(b_i_rdata), .i_ack(b_i_ack),
      .d_re(b_d_re), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata), .d_rdata(b_d_rdata), .d_ack(b_d_ack),
      .stall_if(b_stall_if), .stall_mem(b_stall_mem),
      .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
   );

   // Initial memory image; chosen so address 0x0010 holds 0xB123.
   function automatic logic [15:0] f(input logic [7:0] a);
      return ((16'(a) - 16'h0010) * 16'h0101) ^ 16'hB123;
   endfunction

   function automatic logic [15:0] rnd_addr();
      return 16'($urandom) & 16'hFF07;
   endfunction

   // Memory environment: 256 words indexed by the low address byte.
   logic [15:0]  env_mem [0:255];
   logic [255:0] env_vld;
   logic         env_clr = 1'b0;
   always @(posedge clk) begin
      if (env_clr) env_vld <= '0;
      else if (mem_en && mem_we) begin
         env_mem[mem_addr[7:0]] <= mem_wdata;
         env_vld[mem_addr[7:0]] <= 1'b1;
      end
   end
   assign mem_rdata = (mem_en && !mem_we) ?
                      (env_vld[mem_addr[7:0]] ? env_mem[mem_addr[7:0]] : f(mem_addr[7:0])) : 16'h0000;
   assign b_mem_rdata = b_mem_en ? (b_mem_addr ^ 16'h7E00) : 16'h0000;

   task automatic apply_reset();
      i_req = 0; i_addr = 0; d_re = 0; d_we = 0; d_addr = 0; d_wdata = 0;
      b_i_req = 0; b_i_addr = 0; b_d_re = 0; b_d_we = 0; b_d_addr = 0; b_d_wdata = 0;
      rst = 1; env_clr = 1;
      repeat (2) @(posedge clk);
      #1 rst = 0; env_clr = 0;
   endtask

   task automatic test_reset();
      apply_reset();
      #1;
      n_checks++;
      if ({i_ack, d_ack, i_rdata, d_rdata, mem_en, mem_we, mem_addr, mem_wdata} !== 68'h0) begin
         n_fail++;
         $display("FAIL reset_regs got %h required 0", {i_ack, d_ack, i_rdata, d_rdata, mem_en, mem_we, mem_addr, mem_wdata});
      end
      n_checks++;
      if ({stall_if, stall_mem, b_mem_en, b_i_ack} !== 4'b0) begin
         n_fail++;
         $display("FAIL reset_misc got %b required 0000", {stall_if, stall_mem, b_mem_en, b_i_ack});
      end
   endtask

   task automatic test_fetch();
      apply_reset();
      i_req = 1; i_addr = 16'h0010;
      for (int c = 0; c <= 6; c++) begin
         if (c > 0) begin @(posedge clk); #1; end
         if (c == 6) i_req = 0;
         #1;
         n_checks++;
         if (mem_en !== (c >= 1 && c <= 4)) begin n_fail++; $display("FAIL fetch_mem_en c=%0d got %b", c, mem_en); end
         if (c >= 1 && c <= 4) begin
            n_checks++;
            if (mem_addr !== 16'h0010 || mem_we !== 1'b0) begin
               n_fail++; $display("FAIL fetch_addr c=%0d got %h/%b required 0010/0", c, mem_addr, mem_we);
            end
         end
         n_checks++;
         if (i_ack !== (c == 5) || d_ack !== 1'b0) begin n_fail++; $display("FAIL fetch_ack c=%0d got %b/%b", c, i_ack, d_ack); end
         n_checks++;
         if (stall_if !== (c <= 4)) begin n_fail++; $display("FAIL fetch_stall c=%0d got %b", c, stall_if); end
         n_checks++;
         if (i_rdata !== ((c >= 5) ? 16'hB123 : 16'h0)) begin
            n_fail++; $display("FAIL fetch_rdata c=%0d got %h", c, i_rdata);
         end
      end
   endtask

   task automatic test_write();
      apply_reset();
      d_we = 1; d_addr = 16'h00FE; d_wdata = 16'h5A5A;
      for (int c = 0; c <= 6; c++) begin
         if (c > 0) begin @(posedge clk); #1; end
         if (c == 2) d_addr = 16'h1234;
         if (c == 6) d_we = 0;
         #1;
         n_checks++;
         if (mem_en !== (c >= 1 && c <= 4)) begin n_fail++; $display("FAIL write_mem_en c=%0d got %b", c, mem_en); end
         if (c >= 1 && c <= 4) begin
            n_checks++;
            if (mem_we !== 1'b1 || mem_addr !== 16'h00FE || mem_wdata !== 16'h5A5A) begin
               n_fail++; $display("FAIL write_bus c=%0d got %b/%h/%h required 1/00fe/5a5a", c, mem_we, mem_addr, mem_wdata);
            end
         end
         n_checks++;
         if (d_ack !== (c == 5) || i_ack !== 1'b0) begin n_fail++; $display("FAIL write_ack c=%0d got %b/%b", c, d_ack, i_ack); end
         n_checks++;
         if (stall_mem !== (c <= 4)) begin n_fail++; $display("FAIL write_stall c=%0d got %b", c, stall_mem); end
         n_checks++;
         if (d_rdata !== 16'h0) begin n_fail++; $display("FAIL write_rdata c=%0d got %h required 0", c, d_rdata); end
      end
   endtask

   task automatic test_rw_priority();
      logic [15:0] rd;
      rd = f(8'h40);
      apply_reset();
      d_re = 1; d_addr = 16'h0040;
      for (int c = 0; c <= 12; c++) begin
         if (c > 0) begin @(posedge clk); #1; end
         if (c == 6) begin d_we = 1; d_wdata = 16'h1111; end
         if (c == 12) begin d_we = 0; d_re = 0; end
         #1;
         n_checks++;
         if (mem_en !== ((c >= 1 && c <= 4) || (c >= 7 && c <= 10))) begin
            n_fail++; $display("FAIL rw_mem_en c=%0d got %b", c, mem_en);
         end
         if (c >= 7 && c <= 10) begin
            n_checks++;
            if (mem_we !== 1'b1 || mem_addr !== 16'h0040 || mem_wdata !== 16'h1111) begin
               n_fail++; $display("FAIL rw_write c=%0d got %b/%h/%h required 1/0040/1111", c, mem_we, mem_addr, mem_wdata);
            end
         end
         n_checks++;
         if (d_ack !== (c == 5 || c == 11)) begin n_fail++; $display("FAIL rw_ack c=%0d got %b", c, d_ack); end
         n_checks++;
         if (d_rdata !== ((c >= 5) ? rd : 16'h0)) begin
            n_fail++; $display("FAIL rw_rdata c=%0d got %h required %h", c, d_rdata, (c >= 5) ? rd : 16'h0);
         end
      end
   endtask

   task automatic test_contention();
      int slot, ph;
      logic first_d;
      apply_reset();
      i_req = 1; i_addr = 16'h0020; d_re = 1; d_addr = 16'h0030;
      for (int c = 1; c <= 18; c++) begin
         @(posedge clk); #2;
         slot = (c - 1) / 6; ph = (c - 1) % 6; first_d = (slot % 2 == 0);
         n_checks++;
         if (mem_en !== (ph < 4)) begin n_fail++; $display("FAIL cont_mem_en c=%0d got %b", c, mem_en); end
         if (ph < 4) begin
            n_checks++;
            if (mem_addr !== (first_d ? 16'h0030 : 16'h0020)) begin
               n_fail++; $display("FAIL cont_order c=%0d got %h required %h", c, mem_addr, first_d ? 16'h0030 : 16'h0020);
            end
         end
         n_checks++;
         if (d_ack !== (ph == 4 && first_d) || i_ack !== (ph == 4 && !first_d)) begin
            n_fail++; $display("FAIL cont_ack c=%0d got i=%b d=%b", c, i_ack, d_ack);
         end
         n_checks++;
         if (i_rdata !== ((c >= 11) ? f(8'h20) : 16'h0) || d_rdata !== ((c >= 5) ? f(8'h30) : 16'h0)) begin
            n_fail++; $display("FAIL cont_rdata c=%0d got %h/%h", c, i_rdata, d_rdata);
         end
      end
      i_req = 0; d_re = 0;
   endtask

   task automatic test_reset_mid();
      apply_reset();
      d_we = 1; d_addr = 16'h0050; d_wdata = 16'h9999;
      for (int c = 1; c <= 2; c++) begin
         @(posedge clk); #2;
         n_checks++;
         if (mem_en !== 1'b1 || mem_we !== 1'b1) begin
            n_fail++; $display("FAIL rmid_pre c=%0d got %b/%b required 1/1", c, mem_en, mem_we);
         end
      end
      rst = 1;
      #1;
      n_checks++;
      if ({mem_en, mem_we, i_ack, d_ack, mem_addr, mem_wdata, d_rdata} !== 52'h0) begin
         n_fail++; $display("FAIL rmid_async got %b%b%b%b %h %h %h required all 0", mem_en, mem_we, i_ack, d_ack, mem_addr, mem_wdata, d_rdata);
      end
      @(posedge clk); #1;
      d_we = 0; rst = 0;
      i_req = 1; i_addr = 16'h0010;
      for (int c = 1; c <= 6; c++) begin
         @(posedge clk); #1;
         if (c == 6) i_req = 0;
         #1;
         n_checks++;
         if (d_ack !== 1'b0 || i_ack !== (c == 5) || mem_en !== (c <= 4)) begin
            n_fail++; $display("FAIL rmid_after c=%0d got d_ack=%b i_ack=%b mem_en=%b", c, d_ack, i_ack, mem_en);
         end
         if (c == 5) begin
            n_checks++;
            if (i_rdata !== 16'hB123) begin n_fail++; $display("FAIL rmid_rdata got %h required b123", i_rdata); end
         end
      end
   endtask

   task automatic test_lat1();
      apply_reset();
      b_i_req = 1; b_i_addr = 16'h0003;
      for (int c = 1; c <= 3; c++) begin
         @(posedge clk); #1;
         if (c == 3) b_i_req = 0;
         #1;
         n_checks++;
         if (b_mem_en !== (c == 1) || b_i_ack !== (c == 2)) begin
            n_fail++; $display("FAIL lat1 c=%0d got mem_en=%b i_ack=%b", c, b_mem_en, b_i_ack);
         end
         n_checks++;
         if (b_i_rdata !== ((c >= 2) ? 16'h7E03 : 16'h0)) begin
            n_fail++; $display("FAIL lat1_rdata c=%0d got %h", c, b_i_rdata);
         end
      end
   endtask

   // Transaction-level model: a grant happens in the first cycle the arbiter is
   // free with something pending; it owns the memory for LAT cycles, acks one
   // cycle later and frees the arbiter the cycle after that.
   task automatic test_random();
      logic        i_busy, d_busy, active, win_d, last_d, w_we, exp_en, exp_ia, exp_da;
      logic [15:0] w_addr, w_wd, ei, ed;
      logic [15:0] ref_mem [0:255];
      int          st, op;
      for (int k = 0; k < 256; k++) ref_mem[k] = f(8'(k));
      apply_reset();
      i_busy = 0; d_busy = 0; active = 0; last_d = 0; win_d = 0; w_we = 0;
      w_addr = 0; w_wd = 0; ei = 0; ed = 0; st = 0;
      for (int c = 0; c < 900; c++) begin
         if (c > 0) begin @(posedge clk); #1; end
         if (active && c == st + LAT + 2) begin
            active = 0;
            if (win_d) d_busy = 0; else i_busy = 0;
         end
         if (!i_busy || (active && !win_d)) i_addr = rnd_addr();
         if (!d_busy || (active && win_d)) begin d_addr = rnd_addr(); d_wdata = 16'($urandom); end
         if (!i_busy) begin
            i_req = 0;
            if ($urandom_range(0, 2) == 0) begin i_busy = 1; i_req = 1; end
         end
         if (!d_busy) begin
            d_re = 0; d_we = 0;
            if ($urandom_range(0, 2) == 0) begin
               op = $urandom_range(0, 2);
               d_busy = 1; d_re = (op != 1); d_we = (op != 0);
            end
         end
         if (!active && (i_busy || d_busy)) begin
            win_d  = d_busy && (!i_busy || !last_d);
            last_d = win_d;
            active = 1; st = c;
            w_addr = win_d ? d_addr : i_addr;
            w_we   = win_d && d_we;
            w_wd   = d_wdata;
         end
         #1;
         exp_en = active && c > st && c <= st + LAT;
         exp_ia = active && !win_d && c == st + LAT + 1;
         exp_da = active && win_d && c == st + LAT + 1;
         if (exp_ia) ei = ref_mem[w_addr[7:0]];
         if (exp_da) begin
            if (w_we) ref_mem[w_addr[7:0]] = w_wd;
            else ed = ref_mem[w_addr[7:0]];
         end
         n_checks++;
         if (mem_en !== exp_en || i_ack !== exp_ia || d_ack !== exp_da) begin
            n_fail++; $display("FAIL rand_ctl c=%0d got en=%b ia=%b da=%b required %b %b %b", c, mem_en, i_ack, d_ack, exp_en, exp_ia, exp_da);
         end
         if (exp_en) begin
            n_checks++;
            if (mem_addr !== w_addr || mem_we !== w_we || (w_we && mem_wdata !== w_wd)) begin
               n_fail++; $display("FAIL rand_bus c=%0d got %h/%b/%h required %h/%b/%h", c, mem_addr, mem_we, mem_wdata, w_addr, w_we, w_wd);
            end
         end
         n_checks++;
         if (i_rdata !== ei || d_rdata !== ed) begin
            n_fail++; $display("FAIL rand_rdata c=%0d got %h/%h required %h/%h", c, i_rdata, d_rdata, ei, ed);
         end
         n_checks++;
         if (stall_if !== (i_req && !exp_ia) || stall_mem !== ((d_re || d_we) && !exp_da)) begin
            n_fail++; $display("FAIL rand_stall c=%0d got %b/%b", c, stall_if, stall_mem);
         end
      end
      i_req = 0; d_re = 0; d_we = 0;
   endtask

   initial begin
      test_reset();
      test_fetch();
      test_write();
      test_rw_priority();
      test_contention();
      test_reset_mid();
      test_lat1();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
